// File: rtl/seq_counter_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter_prog
// Brief    : Programmable WIDTH-bit sequence counter with binary up/down,
//            Gray up and table-driven stepping, load and wrap pulse.
// Revision : 1.0  initial release
// ============================================================================

module seq_counter_prog #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tbl_we,
  input  logic [WIDTH-1:0] tbl_addr,
  input  logic [WIDTH-1:0] tbl_data,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam int               C_DEPTH     = 1 << WIDTH;
  localparam logic [1:0]       C_MODE_UP   = 2'b00;
  localparam logic [1:0]       C_MODE_DOWN = 2'b01;
  localparam logic [1:0]       C_MODE_GRAY = 2'b10;
  localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_start;
  logic             r_wrap;
  logic [WIDTH-1:0] r_tbl [C_DEPTH];

  logic [WIDTH-1:0] w_gray_bin;
  logic [WIDTH-1:0] w_gray_inc;
  logic [WIDTH-1:0] w_next;

  function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Table defaults to i -> i+1 so an unprogrammed table behaves as binary up.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_tbl[i] <= WIDTH'((i + 1) % C_DEPTH);
      end
    end else if (tbl_we) begin
      r_tbl[tbl_addr] <= tbl_data;
    end
  end

  always_comb begin
    w_gray_bin = f_gray2bin(r_q);
    w_gray_inc = w_gray_bin + C_ONE;
    w_next     = r_q;
    case (mode)
      C_MODE_UP:   w_next = r_q + C_ONE;
      C_MODE_DOWN: w_next = r_q - C_ONE;
      C_MODE_GRAY: w_next = w_gray_inc ^ (w_gray_inc >> 1);
      default:     w_next = r_tbl[r_q];
    endcase
  end

  // Table lookup above sees the pre-edge entry, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_start <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_q     <= load_value;
      r_start <= load_value;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_q     <= w_next;
      r_wrap  <= (w_next == r_start);
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_seq_counter_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_counter_prog
// Brief    : Self-checking bench for seq_counter_prog (WIDTH=3).
// Revision : 1.0  initial release
// ============================================================================

module tb_seq_counter_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_value;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [2:0] tbl_data;
  logic [2:0] q;
  logic       wrap;

  int checks;
  int failures;

  logic [2:0] m_q;
  logic [2:0] m_start;
  logic       m_wrap;
  logic [2:0] m_tbl [8];

  seq_counter_prog #(.WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .q          (q),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] m_next(input logic [2:0] cur, input int md);
    int v;
    int idx;
    int n;
    v   = int'(cur);
    idx = 0;
    case (md)
      0: return 3'((v + 1) % 8);
      1: return 3'((v + 7) % 8);
      2: begin
        for (int i = 0; i < 8; i++) begin
          if ((i ^ (i >> 1)) == v) idx = i;
        end
        n = (idx + 1) % 8;
        return 3'(n ^ (n >> 1));
      end
      default: return m_tbl[v];
    endcase
  endfunction

  // One clock: drive at negedge, update the model at posedge, return 1ns after.
  task automatic drive(input bit r, input bit l, input bit e, input int md,
                       input int lv, input bit w, input int a, input int d);
    logic [2:0] nq;
    @(negedge clk);
    rst = r; load = l; en = e; mode = 2'(md); load_value = 3'(lv);
    tbl_we = w; tbl_addr = 3'(a); tbl_data = 3'(d);
    @(posedge clk);
    if (r) begin
      m_q = 3'd0; m_start = 3'd0; m_wrap = 1'b0;
      for (int i = 0; i < 8; i++) m_tbl[i] = 3'((i + 1) % 8);
    end else begin
      nq = m_next(m_q, md);
      if (l) begin
        m_q = 3'(lv); m_start = 3'(lv); m_wrap = 1'b0;
      end else if (e) begin
        m_wrap = (nq == m_start);
        m_q = nq;
      end else begin
        m_wrap = 1'b0;
      end
      if (w) m_tbl[a] = 3'(d);
    end
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 1, 3, 5, 1, 0, 4);
    checks++;
    if (q !== 3'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 3, 0, 0, 0, 0);
      checks++;
      if (q !== 3'(k % 8)) begin failures++; $display("FAIL default_tbl_q k=%0d got=%0d exp=%0d", k, q, k % 8); end
      checks++;
      if (wrap !== (k == 8)) begin failures++; $display("FAIL default_tbl_wrap k=%0d got=%0b exp=%0b", k, wrap, k == 8); end
    end
  endtask

  task automatic test_binary_up;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      checks++;
      if (q !== 3'(k % 8)) begin failures++; $display("FAIL up_q k=%0d got=%0d exp=%0d", k, q, k % 8); end
      checks++;
      if (wrap !== (k == 8)) begin failures++; $display("FAIL up_wrap k=%0d got=%0b exp=%0b", k, wrap, k == 8); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q !== 3'd1 || wrap !== 1'b0) begin failures++; $display("FAIL hold q=%0d wrap=%0b exp q=1 wrap=0", q, wrap); end
  endtask

  task automatic test_binary_down;
    drive(0, 1, 1, 1, 2, 0, 0, 0);
    checks++;
    if (q !== 3'd2 || wrap !== 1'b0) begin failures++; $display("FAIL down_load q=%0d wrap=%0b exp q=2 wrap=0", q, wrap); end
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 1, 0, 0, 0, 0);
      checks++;
      if (q !== 3'((2 - k + 16) % 8)) begin failures++; $display("FAIL down_q k=%0d got=%0d exp=%0d", k, q, (2 - k + 16) % 8); end
      checks++;
      if (wrap !== (k == 8)) begin failures++; $display("FAIL down_wrap k=%0d got=%0b exp=%0b", k, wrap, k == 8); end
    end
  endtask

  task automatic test_gray;
    int seq [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    logic [2:0] prev;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    prev = q;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 2, 0, 0, 0, 0);
      checks++;
      if (q !== 3'(seq[k])) begin failures++; $display("FAIL gray_q k=%0d got=%0d exp=%0d", k, q, seq[k]); end
      checks++;
      if ($countones(q ^ prev) != 1) begin failures++; $display("FAIL gray_hamming k=%0d prev=%0d got=%0d exp_dist=1", k, prev, q); end
      checks++;
      if (wrap !== (k == 7)) begin failures++; $display("FAIL gray_wrap k=%0d got=%0b exp=%0b", k, wrap, k == 7); end
      prev = q;
    end
  endtask

  task automatic test_table;
    int addrs [8] = '{0, 6, 4, 7, 3, 1, 2, 5};
    int datas [8] = '{6, 4, 7, 3, 0, 6, 7, 2};
    int seq   [7] = '{2, 7, 3, 0, 6, 4, 7};
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 0, 1, addrs[k], datas[k]);
    checks++;
    if (q !== 3'd0) begin failures++; $display("FAIL tbl_write_keeps_q got=%0d exp=0", q); end
    drive(0, 1, 0, 3, 5, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 1, 3, 0, 0, 0, 0);
      checks++;
      if (q !== 3'(seq[k]) || wrap !== 1'b0) begin
        failures++; $display("FAIL tbl_seq k=%0d q=%0d wrap=%0b exp q=%0d wrap=0", k, q, wrap, seq[k]);
      end
    end
  endtask

  task automatic test_collision;
    int seq  [5] = '{7, 3, 0, 6, 1};
    int wexp [5] = '{0, 0, 0, 1, 0};
    drive(0, 1, 0, 3, 6, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 1, 6, 1);
    checks++;
    if (q !== 3'd4 || wrap !== 1'b0) begin failures++; $display("FAIL collision_old_entry q=%0d wrap=%0b exp q=4 wrap=0", q, wrap); end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 3, 0, 0, 0, 0);
      checks++;
      if (q !== 3'(seq[k]) || wrap !== 1'(wexp[k])) begin
        failures++; $display("FAIL collision_seq k=%0d q=%0d wrap=%0b exp q=%0d wrap=%0d", k, q, wrap, seq[k], wexp[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    drive(1, 1, 1, 3, 5, 1, 6, 2);
    checks++;
    if (q !== 3'd0 || wrap !== 1'b0) begin failures++; $display("FAIL rst_mid q=%0d wrap=%0b exp q=0 wrap=0", q, wrap); end
    drive(0, 1, 1, 3, 6, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    checks++;
    if (q !== 3'd7 || wrap !== 1'b0) begin failures++; $display("FAIL rst_mid_tbl_default q=%0d wrap=%0b exp q=7 wrap=0", q, wrap); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 40) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
            int'($urandom % 4), int'($urandom % 8), ($urandom % 3) == 0,
            int'($urandom % 8), int'($urandom % 8));
      checks++;
      if (q !== m_q || wrap !== m_wrap) begin
        failures++; $display("FAIL random k=%0d q=%0d wrap=%0b exp q=%0d wrap=%0b", k, q, wrap, m_q, m_wrap);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_value = 3'd0;
    tbl_we = 1'b0; tbl_addr = 3'd0; tbl_data = 3'd0;
    m_q = 3'd0; m_start = 3'd0; m_wrap = 1'b0;
    for (int i = 0; i < 8; i++) m_tbl[i] = 3'((i + 1) % 8);
    test_reset();
    test_binary_up();
    test_binary_down();
    test_gray();
    test_table();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_counter_prog.md
Name: seq_counter_prog

Overview:
- Parametrised synchronous sequence counter that steps a WIDTH-bit state through one of four modes: binary up, binary down, Gray up, or a user-programmed next-state table.
- Supports synchronous load, enable and a sequence-complete pulse.
- Serves as the general-purpose successor to the fixed 3-bit custom-sequence counters in the lab designs.
- All state changes are synchronous; there are no asynchronous preset or clear paths.

Parameters:
- WIDTH, 3, state/output width in bits (1..8); the table has 2^WIDTH entries.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  step enable; one step per cycle while high
- mode  input  2  00 binary up, 01 binary down, 10 Gray up, 11 table
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value for q and start register on load
- tbl_we  input  1  table write strobe
- tbl_addr  input  WIDTH  table entry index (current state)
- tbl_data  input  WIDTH  next state to store at tbl_addr
- q  output  WIDTH  current state (registered)
- wrap  output  1  registered one-cycle pulse: last step landed on start value

Behaviour:
- Reset (rst=1 at a clock edge):
  - q=0, start=0, wrap=0.
  - Every table entry i is set to (i+1) mod 2^WIDTH, so table mode defaults to binary up.
  - Table writes presented in the same cycle are ignored.
- Priority per edge: rst > load > en step > hold.
- Load (load=1, rst=0):
  - q<=load_value and start<=load_value; wrap<=0.
  - en is ignored in that cycle.
- Step (en=1, load=0, rst=0): q<=next(q), computed by mode:
  - 00: q+1 mod 2^WIDTH; 2^WIDTH-1 wraps to 0.
  - 01: q-1 mod 2^WIDTH; 0 wraps to 2^WIDTH-1.
  - 10: q is treated as Gray code; next = bin2gray(gray2bin(q)+1 mod 2^WIDTH), so exactly one bit changes per step. A q that was loaded in another mode is reinterpreted as Gray with no conversion.
  - 11: next = table[q].
- Latency: one step takes effect at the next edge; q is updated one cycle after en is sampled.
- wrap:
  - wrap<=1 on a step edge where next(q)==start; otherwise wrap<=0.
  - A hold (en=0) clears wrap.
  - A self-loop table entry equal to start (table[start]==start) pulses wrap on every step.
- Mode changes take effect at the sampled edge; q is never altered by a mode change alone.
- Table write (tbl_we=1, rst=0) with a simultaneous step:
  - A step in mode 11 reads the old entry (read-before-write); the new entry is visible from the next cycle.
  - tbl_we is accepted in any mode and independently of load and en.
- Table writes never modify q or start.
- Reset mid-sequence:
  - q returns to 0 and the table returns to default on the same edge.
  - Previously programmed entries are lost.
- No illegal states: every q value has a defined successor in all modes.

Test Plan:
- Reset then mode=00, en=1 for 9 cycles (WIDTH=3) -> q: 0,1,2,...,7,0,1; wrap pulses the cycle q returns to 0.
- load=1 with load_value=2, then mode=01, en=1 for 4 cycles -> q: 2,1,0,7,6; no wrap until q returns to 2 after 8 steps.
- mode=10 from q=0, 8 steps -> q: 0,1,3,2,6,7,5,4,0; Hamming distance 1 between successive values; wrap on return to 0.
- Program table: 0->6, 6->4, 4->7, 7->3, 3->0, 1->6, 2->7, 5->2; then load 5, mode=11, en=1 -> q: 5,2,7,3,0,6,4,7; wrap pulses only at the second visit of 5 (never here), so no wrap.
- In table mode at q=6, write tbl_addr=6, tbl_data=1 in the same cycle as a step -> q=4 (old entry); the next visit to 6 steps to 1.
- rst asserted mid-table-sequence, together with load=1 and tbl_we=1 -> q=0, wrap=0, table[6]=7 (default); the load and the write are both ignored.
